// File: rtl/if_prefetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_prefetch_unit_if: redirect, imem and decode-side bundle        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface if_prefetch_unit_if #(
  parameter int XLEN = 32
);
  logic            Trap_Return;
  logic            Take_trap;
  logic            Branch_taken;
  logic [XLEN-1:0] EPC_OUT;
  logic [XLEN-1:0] MTVEC;
  logic [XLEN-1:0] target_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            id_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;

  modport master (
    input  Trap_Return, Take_trap, Branch_taken, EPC_OUT, MTVEC, target_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, pc
  );

  modport slave (
    output Trap_Return, Take_trap, Branch_taken, EPC_OUT, MTVEC, target_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, pc
  );
endinterface
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_prefetch_unit: decoupled instruction fetch with prefetch FIFO  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module if_prefetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  if_prefetch_unit_if.master bus
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   ONE     = 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP    = 4;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0] instr_mem [FIFO_DEPTH];

  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_flight;
  logic            fifo_empty;
  logic            accept;
  logic            rsp;
  logic            pop;
  logic [CW-1:0]   outstanding_nxt;

  assign redirect   = bus.Trap_Return | bus.Take_trap | bus.Branch_taken;
  assign target_raw = bus.Trap_Return ? bus.EPC_OUT :
                      bus.Take_trap   ? bus.MTVEC   : bus.target_pc;
  assign target     = {target_raw[XLEN-1:2], 2'b00};

  // Requests are only issued while every in-flight word has a FIFO slot waiting
  assign fifo_count = wr_ptr - rd_ptr;
  assign in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};
  assign fifo_empty = (wr_ptr == rd_ptr);

  assign bus.imem_req_valid = !rst && !redirect && (in_flight < DEPTH_W);
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = !fifo_empty;
  assign bus.instr          = instr_mem[rd_ptr[PW-1:0]];
  assign bus.pc             = pc_mem[rd_ptr[PW-1:0]];

  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp    = bus.imem_rsp_valid;
  assign pop    = !fifo_empty && bus.id_ready && !redirect;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({accept, rsp})
      2'b10:   outstanding_nxt = outstanding + ONE;
      2'b01:   outstanding_nxt = outstanding - ONE;
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= BOOT_ADDRESS;
      rsp_pc      <= BOOT_ADDRESS;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= BOOT_ADDRESS;
        instr_mem[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        // Everything still in flight is stale; a response arriving now is dropped too
        fetch_pc <= target;
        rsp_pc   <= target;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        discard  <= rsp ? (outstanding - ONE) : outstanding;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + STEP;
        end
        if (rsp) begin
          if (discard != '0) begin
            discard <= discard - ONE;
          end else begin
            pc_mem[wr_ptr[PW-1:0]]    <= rsp_pc;
            instr_mem[wr_ptr[PW-1:0]] <= bus.imem_rsp_data;
            wr_ptr                    <= wr_ptr + ONE;
            rsp_pc                    <= rsp_pc + STEP;
          end
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_if_prefetch_unit: directed vectors with an in-order imem model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_if_prefetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 1;
  int   cyc   = 0;

  always #5 clk = ~clk;

  if_prefetch_unit_if #(.XLEN(32)) bus ();

  if_prefetch_unit #(
    .XLEN        (32),
    .BOOT_ADDRESS(32'h0000_0000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction

  // In-order memory: a request accepted at one edge answers `lat` cycles later
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic idr, input logic rdy,
                       input logic tr, input logic tt, input logic br);
    @(negedge clk);
    rst                = r;
    bus.id_ready       = idr;
    bus.imem_req_ready = rdy;
    bus.Trap_Return    = tr;
    bus.Take_trap      = tt;
    bus.Branch_taken   = br;
    #1;
  endtask

  task automatic do_reset(input int l, input logic idr);
    drive(1'b1, idr, 1'b1, 1'b0, 1'b0, 1'b0);
    lat = l;
    drive(1'b1, idr, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_head(input string nm, input logic [31:0] exp_pc);
    chk({nm, " iv"}, 32'(bus.instr_valid), 32'd1);
    chk({nm, " pc"}, bus.pc, exp_pc);
    chk({nm, " instr"}, bus.instr, mem_word(exp_pc));
  endtask

  // hm: 0 = head not checked, 1 = head pc/instr, 2 = reset head values
  typedef struct {
    logic        rst;
    logic        idr;
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    int          hm;
    logic [31:0] hpc;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic idr, input logic rv,
                              input logic [31:0] ra, input logic iv, input int hm,
                              input logic [31:0] hpc);
    vec_t v;
    v.rst = r; v.idr = idr; v.rv = rv; v.ra = ra; v.iv = iv; v.hm = hm; v.hpc = hpc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Trap_Return    = 1'b0;
    bus.Take_trap      = 1'b0;
    bus.Branch_taken   = 1'b0;
    bus.EPC_OUT        = 32'h0000_0200;
    bus.MTVEC          = 32'h0000_0300;
    bus.target_pc      = 32'h0000_0400;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    // Streaming from reset, then a mid-stream reset into a stalled decode
    tv.push_back(mk(1, 1, 0, 32'h00, 0, 2, 32'h00));
    tv.push_back(mk(0, 1, 1, 32'h00, 0, 0, 32'h00));
    tv.push_back(mk(0, 1, 1, 32'h04, 0, 0, 32'h00));
    tv.push_back(mk(0, 1, 1, 32'h08, 1, 1, 32'h00));
    tv.push_back(mk(0, 1, 1, 32'h0C, 1, 1, 32'h04));
    tv.push_back(mk(0, 1, 1, 32'h10, 1, 1, 32'h08));
    tv.push_back(mk(1, 0, 0, 32'h00, 1, 1, 32'h0C));
    tv.push_back(mk(0, 0, 1, 32'h00, 0, 2, 32'h00));
    tv.push_back(mk(0, 0, 1, 32'h04, 0, 0, 32'h00));
    tv.push_back(mk(0, 0, 1, 32'h08, 1, 1, 32'h00));
    tv.push_back(mk(0, 0, 1, 32'h0C, 1, 1, 32'h00));
    tv.push_back(mk(0, 0, 0, 32'h00, 1, 1, 32'h00));
    tv.push_back(mk(0, 0, 0, 32'h00, 1, 1, 32'h00));
    tv.push_back(mk(0, 0, 0, 32'h00, 1, 1, 32'h00));
    tv.push_back(mk(0, 1, 0, 32'h00, 1, 1, 32'h00));
    tv.push_back(mk(0, 1, 1, 32'h10, 1, 1, 32'h04));
    tv.push_back(mk(0, 1, 1, 32'h14, 1, 1, 32'h08));
    tv.push_back(mk(0, 1, 1, 32'h18, 1, 1, 32'h0C));
    tv.push_back(mk(0, 1, 1, 32'h1C, 1, 1, 32'h10));

    do_reset(1, 1'b1);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].idr, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d req_valid", i), 32'(bus.imem_req_valid), 32'(tv[i].rv));
      if (tv[i].rv) chk($sformatf("v%0d req_addr", i), bus.imem_req_addr, tv[i].ra);
      chk($sformatf("v%0d instr_valid", i), 32'(bus.instr_valid), 32'(tv[i].iv));
      if (tv[i].hm == 1) begin
        chk($sformatf("v%0d pc", i), bus.pc, tv[i].hpc);
        chk($sformatf("v%0d instr", i), bus.instr, mem_word(tv[i].hpc));
      end else if (tv[i].hm == 2) begin
        chk($sformatf("v%0d rst pc", i), bus.pc, 32'h0);
        chk($sformatf("v%0d rst instr", i), bus.instr, 32'h0);
      end
    end

    // Branch with stale responses in flight on a 3-cycle memory
    bus.target_pc = 32'h0000_0100;
    do_reset(3, 1'b1);
    drive(0, 1, 1, 0, 0, 0);
    chk("br req0", bus.imem_req_addr, 32'h0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    chk("br iv_pre", 32'(bus.instr_valid), 32'd0);
    drive(0, 1, 1, 0, 0, 1);
    chk("br req_withdrawn", 32'(bus.imem_req_valid), 32'd0);
    chk_head("br head_before", 32'h0);
    drive(0, 1, 1, 0, 0, 0);
    chk("br flushed", 32'(bus.instr_valid), 32'd0);
    chk("br req_target", bus.imem_req_addr, 32'h100);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      chk($sformatf("br stale%0d", k), 32'(bus.instr_valid), 32'd0);
    end
    drive(0, 1, 1, 0, 0, 0);
    chk_head("br first", 32'h100);
    drive(0, 1, 1, 0, 0, 0);
    chk_head("br second", 32'h104);

    // Redirect priority, plus discard reload on a second redirect
    bus.target_pc = 32'h0000_0400;
    do_reset(3, 1'b1);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 1, 1);
    chk("pri all_req", 32'(bus.imem_req_valid), 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    chk("pri epc", bus.imem_req_addr, 32'h200);
    drive(0, 1, 1, 0, 1, 1);
    chk("pri tt_req", 32'(bus.imem_req_valid), 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    chk("pri mtvec", bus.imem_req_addr, 32'h300);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      chk($sformatf("pri stale%0d", k), 32'(bus.instr_valid), 32'd0);
    end
    drive(0, 1, 1, 0, 0, 0);
    chk_head("pri first", 32'h300);

    // Memory stall holds the address; a redirect withdraws the request
    bus.target_pc = 32'h0000_0503;
    do_reset(1, 1'b1);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      chk($sformatf("stall%0d valid", k), 32'(bus.imem_req_valid), 32'd1);
      chk($sformatf("stall%0d addr", k), bus.imem_req_addr, 32'h8);
    end
    drive(0, 1, 0, 0, 0, 1);
    chk("stall redirect", 32'(bus.imem_req_valid), 32'd0);
    drive(0, 1, 1, 0, 0, 0);
    chk("stall new_addr", bus.imem_req_addr, 32'h500);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    chk_head("stall first", 32'h500);

    // Reset pulse with the FIFO full
    do_reset(1, 1'b0);
    for (int k = 0; k < 6; k++) drive(0, 0, 1, 0, 0, 0);
    chk("full req", 32'(bus.imem_req_valid), 32'd0);
    chk_head("full head", 32'h0);
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    chk("rst6 iv", 32'(bus.instr_valid), 32'd0);
    chk("rst6 pc", bus.pc, 32'h0);
    chk("rst6 instr", bus.instr, 32'h0);
    chk("rst6 addr", bus.imem_req_addr, 32'h0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    chk_head("rst6 first", 32'h0);
    drive(0, 1, 1, 0, 0, 0);
    chk_head("rst6 second", 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
